ifu_fetch: RTL and testbench

- Instruction fetch unit sitting directly upstream of the main decoder.
- Holds the PC register and the instruction ROM, and computes next-PC.
- Presents the fetched 32-bit instruction to the decoder.
- Consumes the decoder's Branch/Jump/jr controls, the ALU Zero flag and the rs register value to redirect fetch; supplies the link value written by jal.

---
 rtl/mips_pkg.sv | 14 +
 rtl/ifu_npc.sv | 68 ++++++
 rtl/ifu_fetch.sv | 113 +++++++++++
 tb/tb_ifu_fetch.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS constants for the fetch slice.
package mips_pkg;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam int          IM_DEPTH_DEF = 1024;

    localparam logic [5:0]  OP_BEQ   = 6'h04;
    localparam logic [5:0]  OP_J     = 6'h02;
    localparam logic [5:0]  OP_JAL   = 6'h03;
    localparam logic [5:0]  FUNCT_JR = 6'h08;

    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/ifu_npc.sv
// Next-PC selection: sequential/branch/jump/jr targets and ROM range check.
// With IFU_DELAY_SLOT_EN a taken redirect is exported instead of applied.
module ifu_npc
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter int          IM_DEPTH = IM_DEPTH_DEF
) (
    input  logic [31:0] pc,
    input  logic [25:0] imm,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    input  logic        jr,
    input  logic [31:0] rs_data,
`ifdef IFU_DELAY_SLOT_EN
    input  logic        pend_valid,
    input  logic [31:0] pend_target,
    output logic        take,
    output logic [31:0] tgt_pc,
`endif
    output logic [31:0] seq_pc,
    output logic [31:0] npc,
    output logic        npc_bad
);

    localparam logic [32:0] PC_END =
        {1'b0, PC_RESET} + 33'(IM_DEPTH) * 33'd4;

`ifndef IFU_DELAY_SLOT_EN
    logic        take;
    logic [31:0] tgt_pc;
`endif
    logic [31:0] br_pc;
    logic [31:0] jt_pc;

    assign seq_pc = pc + 32'd4;
    assign br_pc  = seq_pc + {{14{imm[15]}}, imm[15:0], 2'b00};
    assign jt_pc  = {seq_pc[31:28], imm, 2'b00};

    always_comb begin
        take   = 1'b0;
        tgt_pc = seq_pc;
        if (Jump && jr) begin
            take   = 1'b1;
            tgt_pc = rs_data;
        end else if (Jump) begin
            take   = 1'b1;
            tgt_pc = jt_pc;
        end else if (Branch && Zero) begin
            take   = 1'b1;
            tgt_pc = br_pc;
        end
    end

    always_comb begin
`ifdef IFU_DELAY_SLOT_EN
        // Delay slot always runs; a pending target lands one edge later.
        npc = pend_valid ? pend_target : seq_pc;
`else
        npc = take ? tgt_pc : seq_pc;
`endif
        npc_bad = (npc[1:0] != 2'b00)
               || (npc < PC_RESET)
               || ({1'b0, npc} >= PC_END);
    end

endmodule

// File: rtl/ifu_fetch.sv
// Fetch unit: PC register, instruction ROM, sticky fault flag.
// IFU_DELAY_SLOT_EN enables MIPS branch-delay-slot redirect timing.
module ifu_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter int          IM_DEPTH = IM_DEPTH_DEF,
    parameter string       IM_FILE  = "code.txt"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    input  logic        jr,
    input  logic [31:0] rs_data,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] link_pc,
    output logic        fault
);

    localparam int IDX_W = $clog2(IM_DEPTH);

    logic [31:0] rom [IM_DEPTH];

    logic [31:0]      pc_q, pc_d;
    logic             fault_q, fault_d;
    logic [IDX_W-1:0] rom_idx;
    logic [31:0]      seq_pc;
    logic [31:0]      npc;
    logic             npc_bad;

    assign rom_idx = IDX_W'((pc_q - PC_RESET) >> 2);
    assign instr   = fault_q ? NOP : rom[rom_idx];
    assign pc      = pc_q;
    assign fault   = fault_q;

`ifdef IFU_DELAY_SLOT_EN
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        take;
    logic [31:0] tgt_pc;

    assign link_pc = pc_q + 32'd8;
`else
    assign link_pc = seq_pc;
`endif

    ifu_npc #(
        .PC_RESET (PC_RESET),
        .IM_DEPTH (IM_DEPTH)
    ) u_npc (
        .pc          (pc_q),
        .imm         (instr[25:0]),
        .Branch      (Branch),
        .Zero        (Zero),
        .Jump        (Jump),
        .jr          (jr),
        .rs_data     (rs_data),
`ifdef IFU_DELAY_SLOT_EN
        .pend_valid  (pend_valid_q),
        .pend_target (pend_target_q),
        .take        (take),
        .tgt_pc      (tgt_pc),
`endif
        .seq_pc      (seq_pc),
        .npc         (npc),
        .npc_bad     (npc_bad)
    );

    always_comb begin
        pc_d    = pc_q;
        fault_d = fault_q;
`ifdef IFU_DELAY_SLOT_EN
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
`endif
        if (!stall && !fault_q) begin
            if (npc_bad) begin
                fault_d = 1'b1;
            end else begin
                pc_d = npc;
`ifdef IFU_DELAY_SLOT_EN
                pend_valid_d = !pend_valid_q && take;
                if (!pend_valid_q && take) begin
                    pend_target_d = tgt_pc;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            fault_q <= 1'b0;
`ifdef IFU_DELAY_SLOT_EN
            pend_valid_q  <= 1'b0;
            pend_target_q <= PC_RESET;
`endif
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
`ifdef IFU_DELAY_SLOT_EN
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
`endif
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized self-checking bench for ifu_fetch against a behavioural model.
module tb_ifu_fetch;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        Branch = 1'b0;
    logic        Zero = 1'b0;
    logic        Jump = 1'b0;
    logic        jr = 1'b0;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] link_pc;
    logic        fault;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_rom [DEPTH];
    logic [31:0] m_pc;
    logic        m_fault;
    logic        m_pv;
    logic [31:0] m_pt;

    ifu_fetch #(
        .PC_RESET (BASE),
        .IM_DEPTH (DEPTH),
        .IM_FILE  ("")
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .Branch  (Branch),
        .Zero    (Zero),
        .Jump    (Jump),
        .jr      (jr),
        .rs_data (rs_data),
        .instr   (instr),
        .pc      (pc),
        .link_pc (link_pc),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic in_rom(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (a % 4 == 0) && off >= 0 && off < 4 * DEPTH;
    endfunction

    function automatic logic [31:0] m_instr();
        if (m_fault) return 32'h0;
        return m_rom[((m_pc - BASE) / 4) % DEPTH];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".instr"}, instr, m_instr());
        chk({tag, ".fault"}, {31'h0, fault}, {31'h0, m_fault});
`ifdef IFU_DELAY_SLOT_EN
        chk({tag, ".link"}, link_pc, m_pc + 8);
`else
        chk({tag, ".link"}, link_pc, m_pc + 4);
`endif
    endtask

    // One clock: apply inputs, advance the model by the architectural rules.
    task automatic cyc(input logic r, input logic st, input logic b,
                       input logic z, input logic j, input logic jrr,
                       input logic [31:0] rs);
        logic [31:0] ins, seq, t, nxt;
        logic        tk;
        reset = r; stall = st; Branch = b; Zero = z;
        Jump = j; jr = jrr; rs_data = rs;
        ins = m_instr();
        @(posedge clk);
        if (r) begin
            m_pc = BASE; m_fault = 1'b0; m_pv = 1'b0;
        end else if (!m_fault && !st) begin
            seq = m_pc + 4;
            tk  = 1'b1;
            if (j && jrr)
                t = rs;
            else if (j)
                t = (seq & 32'hF000_0000) | ({6'h0, ins[25:0]} * 4);
            else if (b && z)
                t = seq + 32'($signed(ins[15:0])) * 4;
            else begin
                t = seq; tk = 1'b0;
            end
`ifdef IFU_DELAY_SLOT_EN
            nxt = m_pv ? m_pt : seq;
            if (!in_rom(nxt)) m_fault = 1'b1;
            else begin
                if (!m_pv && tk) begin m_pv = 1'b1; m_pt = t; end
                else m_pv = 1'b0;
                m_pc = nxt;
            end
`else
            nxt = tk ? t : seq;
            if (!in_rom(nxt)) m_fault = 1'b1;
            else m_pc = nxt;
`endif
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 3) != 0)
                w[25:0] = 26'h0000c00 + 26'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0)
                w[15:0] = 16'($signed(-$urandom_range(1, 8)));
            m_rom[i] = w;
        end
        m_rom[0] = 32'h3c01_0001;
        m_rom[1] = 32'h3421_0002;
        m_rom[2] = 32'h0000_0000;
        m_rom[3] = 32'h1000_fffe;
        m_rom[4] = 32'h0800_0c10;
        for (int i = 0; i < DEPTH; i++) dut.rom[i] = m_rom[i];
        m_pc = 32'h0; m_fault = 1'b0; m_pv = 1'b0; m_pt = 32'h0;

        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        chk("rst.pc", pc, 32'h3000);
        chk("rst.fault", {31'h0, fault}, 32'h0);
        chk("rst.instr", instr, 32'h3c01_0001);
        check_all("rst");
        cyc(0, 0, 0, 0, 0, 0, 32'h0);
        chk("seq1.pc", pc, 32'h3004);
        chk("seq1.instr", instr, 32'h3421_0002);
        cyc(0, 0, 0, 0, 0, 0, 32'h0);
        chk("seq2.pc", pc, 32'h3008);
        chk("seq2.instr", instr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 1, 1, 0, 32'h0);
            chk("stall.pc", pc, 32'h3008);
            chk("stall.instr", instr, 32'h0);
        end
        cyc(0, 0, 0, 0, 0, 0, 32'h0);
        chk("unstall.pc", pc, 32'h300c);
`ifndef IFU_DELAY_SLOT_EN
        cyc(0, 0, 1, 1, 0, 0, 32'h0);
        chk("beq_t.pc", pc, 32'h3008);
        idle(1);
        cyc(0, 0, 1, 0, 0, 0, 32'h0);
        chk("beq_nt.pc", pc, 32'h3010);
        chk("j.link", link_pc, 32'h3014);
        cyc(0, 0, 0, 0, 1, 0, 32'h0);
        chk("j.pc", pc, 32'h3040);
        cyc(0, 0, 0, 0, 1, 1, 32'h300c);
        chk("jr.pc", pc, 32'h300c);
        cyc(0, 0, 0, 0, 0, 1, 32'h5000);
        chk("jr_nojump.pc", pc, 32'h3010);
        cyc(0, 0, 0, 0, 1, 1, 32'h3002);
        chk("mis.fault", {31'h0, fault}, 32'h1);
        chk("mis.pc", pc, 32'h3010);
        chk("mis.instr", instr, 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 32'h0);
        idle(2);
        chk("sticky.pc", pc, 32'h3010);
        chk("sticky.fault", {31'h0, fault}, 32'h1);
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        chk("clr.pc", pc, 32'h3000);
        chk("clr.fault", {31'h0, fault}, 32'h0);
        cyc(0, 0, 0, 0, 1, 1, 32'h4000);
        chk("oor.fault", {31'h0, fault}, 32'h1);
        chk("oor.pc", pc, 32'h3000);
        cyc(1, 1, 0, 0, 0, 0, 32'h0);
        chk("rst_stall.pc", pc, 32'h3000);
        chk("rst_stall.fault", {31'h0, fault}, 32'h0);
`else
        idle(1);
        chk("ds.at_j", pc, 32'h3010);
        chk("ds.link", link_pc, 32'h3018);
        cyc(0, 0, 0, 0, 1, 0, 32'h0);
        chk("ds.slot", pc, 32'h3014);
        cyc(0, 0, 0, 0, 1, 1, 32'h3000);
        chk("ds.target", pc, 32'h3040);
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        chk("ds.rst", pc, 32'h3000);
`endif
        check_all("dir");

        for (int i = 0; i < 600; i++) begin
            logic        r, st, b, z, j, q;
            logic [31:0] rs;
            r  = ($urandom_range(0, 24) == 0);
            st = ($urandom_range(0, 5) == 0);
            b  = ($urandom_range(0, 4) == 0);
            z  = $urandom_range(0, 1);
            j  = ($urandom_range(0, 5) == 0);
            q  = ($urandom_range(0, 2) == 0);
            rs = BASE + 4 * $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 7) == 0) rs = $urandom;
            cyc(r, st, b, z, j, q, rs);
            check_all("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
